// File: rtl/hoeraa_err_eval_ctrl.sv
// HOERAA error-characterisation sequencer.
// Two Galois LFSRs feed operand pairs to an external combinational HOERAA
// adder. Each approximate result is compared with the exact sum, and the run
// accumulates the error count, the maximum error distance and a saturating
// sum of error distances. A busy/done handshake reports the end of a run.
module hoeraa_err_eval_ctrl #(
  parameter int         N     = 16,
  parameter int         CNT_W = 16,
  parameter int         ACC_W = 32,
  parameter logic [N-1:0] TAPS  = 16'hB400,
  parameter logic [N-1:0] YMASK = 16'h5A5A
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic [N-1:0]     seed,
  output logic [N-1:0]     adder_x,
  output logic [N-1:0]     adder_y,
  input  logic [N-1:0]     adder_s,
  input  logic             adder_co,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [N:0]       max_ed,
  output logic [ACC_W-1:0] sum_ed,
  output logic             sat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough to hold the accumulator plus one error distance without wrap,
  // even when ACC_W is narrower than an error distance.
  localparam int SUM_W = ((ACC_W > N + 1) ? ACC_W : N + 1) + 1;
  localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W - ACC_W){1'b0}}, {ACC_W{1'b1}}};
  localparam logic [N-1:0]     LFSR_ONE = {{(N - 1){1'b0}}, 1'b1};

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
    logic [N-1:0] sh;
    sh = v >> 1;
    if (v[0]) begin
      lfsr_step = sh ^ TAPS;
    end else begin
      lfsr_step = sh;
    end
  endfunction

  // Absolute difference of two (N+1)-bit values.
  function automatic logic [N:0] abs_diff(input logic [N:0] a, input logic [N:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

  logic [1:0]       state_r;
  logic [CNT_W-1:0] counter_r;
  logic [CNT_W-1:0] n_r;
  logic [N-1:0]     x_r;
  logic [N-1:0]     y_r;
  logic [CNT_W-1:0] err_r;
  logic [N:0]       max_r;
  logic [ACC_W-1:0] sum_r;
  logic             sat_r;
  logic             busy_r;
  logic             done_r;

  logic [N:0]       exact_s;
  logic [N:0]       approx_s;
  logic [N:0]       ed_s;
  logic [SUM_W-1:0] sum_wide_s;
  logic             sum_ovf_s;
  logic [ACC_W-1:0] sum_next_s;
  logic [N-1:0]     seed_x_s;
  logic [N-1:0]     seed_y_s;
  logic             last_s;

  // Per-sample error distance and saturating accumulation.
  always_comb begin
    exact_s    = {1'b0, x_r} + {1'b0, y_r};
    approx_s   = {adder_co, adder_s};
    ed_s       = abs_diff(exact_s, approx_s);
    sum_wide_s = SUM_W'(sum_r) + SUM_W'(ed_s);
    sum_ovf_s  = (sum_wide_s > ACC_MAX);
    if (sum_ovf_s) begin
      sum_next_s = {ACC_W{1'b1}};
    end else begin
      sum_next_s = sum_wide_s[ACC_W-1:0];
    end
    last_s = (counter_r == (n_r - {{(CNT_W - 1){1'b0}}, 1'b1}));
  end

  // LFSR seeds; an all-zero state would lock the LFSR, so it becomes 1.
  always_comb begin
    if (seed == {N{1'b0}}) begin
      seed_x_s = LFSR_ONE;
    end else begin
      seed_x_s = seed;
    end
    if ((seed ^ YMASK) == {N{1'b0}}) begin
      seed_y_s = LFSR_ONE;
    end else begin
      seed_y_s = seed ^ YMASK;
    end
  end

  // Sequencer FSM, operand LFSRs and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      counter_r <= {CNT_W{1'b0}};
      n_r       <= {CNT_W{1'b0}};
      x_r       <= {N{1'b0}};
      y_r       <= {N{1'b0}};
      err_r     <= {CNT_W{1'b0}};
      max_r     <= {(N + 1){1'b0}};
      sum_r     <= {ACC_W{1'b0}};
      sat_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            n_r       <= num_samples;
            counter_r <= {CNT_W{1'b0}};
            err_r     <= {CNT_W{1'b0}};
            max_r     <= {(N + 1){1'b0}};
            sum_r     <= {ACC_W{1'b0}};
            sat_r     <= 1'b0;
            if (num_samples != {CNT_W{1'b0}}) begin
              x_r     <= seed_x_s;
              y_r     <= seed_y_s;
              state_r <= ST_RUN;
              busy_r  <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          if (ed_s != {(N + 1){1'b0}}) begin
            err_r <= err_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          end
          if (ed_s > max_r) begin
            max_r <= ed_s;
          end
          sum_r     <= sum_next_s;
          sat_r     <= sat_r | sum_ovf_s;
          x_r       <= lfsr_step(x_r);
          y_r       <= lfsr_step(y_r);
          counter_r <= counter_r + {{(CNT_W - 1){1'b0}}, 1'b1};
          if (last_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            busy_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign adder_x   = x_r;
  assign adder_y   = y_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err_count = err_r;
  assign max_ed    = max_r;
  assign sum_ed    = sum_r;
  assign sat       = sat_r;

endmodule

// File: tb/tb_hoeraa_err_eval_ctrl.sv
// Self-checking bench for hoeraa_err_eval_ctrl: mock adders, randomized runs
// and a reference model built on plain integer arithmetic.
module tb_hoeraa_err_eval_ctrl;

  localparam logic [15:0] TAPS  = 16'hB400;
  localparam logic [15:0] YMASK = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_samples;
  logic [15:0] seed;

  logic [15:0] x1, y1, s1;
  logic        co1, busy1, done1, sat1;
  logic [15:0] err1;
  logic [16:0] max1;
  logic [31:0] sum1;

  logic [15:0] x2, y2;
  logic        busy2, done2, sat2;
  logic [15:0] err2;
  logic [16:0] max2;
  logic [15:0] sum2;

  int mode;
  int nchecks = 0;
  int nerrors = 0;

  // Expected operand registers carried across runs.
  logic [15:0] exp_x = 16'h0000;
  logic [15:0] exp_y = 16'h0000;

  always #5 clk = ~clk;

  // Mock adders: 0 exact, 1 all-zero output, 2 lower-part-OR approximate
  // adder (K=6), 3 operand-dependent corruption.
  function automatic logic [16:0] mock(input int md, input logic [15:0] x, input logic [15:0] y);
    logic [16:0] ex;
    logic [10:0] hi;
    ex = {1'b0, x} + {1'b0, y};
    case (md)
      0: mock = ex;
      1: mock = 17'h00000;
      2: begin
        hi   = {1'b0, x[15:6]} + {1'b0, y[15:6]} + {10'd0, x[5] & y[5]};
        mock = {hi, x[5:0] | y[5:0]};
      end
      default: mock = ex ^ {y[0], 8'h00, x[7:0] & y[15:8]};
    endcase
  endfunction

  assign {co1, s1} = mock(mode, x1, y1);

  hoeraa_err_eval_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .seed(seed),
    .adder_x(x1), .adder_y(y1), .adder_s(s1), .adder_co(co1),
    .busy(busy1), .done(done1), .err_count(err1), .max_ed(max1),
    .sum_ed(sum1), .sat(sat1)
  );

  hoeraa_err_eval_ctrl #(.ACC_W(16)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples), .seed(seed),
    .adder_x(x2), .adder_y(y2), .adder_s(16'h0000), .adder_co(1'b0),
    .busy(busy2), .done(done2), .err_count(err2), .max_ed(max2),
    .sum_ed(sum2), .sat(sat2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Galois step written arithmetically.
  function automatic logic [15:0] next_lfsr(input logic [15:0] v);
    int u;
    u = int'(v) / 2;
    if ((int'(v) % 2) == 1) u = u ^ int'(TAPS);
    return u[15:0];
  endfunction

  int    ref_err, ref_max, ref_err2, ref_max2;
  longint ref_sum, ref_sum2;
  bit    ref_sat, ref_sat2;

  task automatic check_stats(input string tag);
    check({tag, "_err"},  err1, ref_err);
    check({tag, "_max"},  max1, ref_max);
    check({tag, "_sum"},  sum1, ref_sum);
    check({tag, "_sat"},  sat1, ref_sat);
    check({tag, "_err2"}, err2, ref_err2);
    check({tag, "_max2"}, max2, ref_max2);
    check({tag, "_sum2"}, sum2, ref_sum2);
    check({tag, "_sat2"}, sat2, ref_sat2);
    check({tag, "_x"}, x1, exp_x);
    check({tag, "_y"}, y1, exp_y);
  endtask

  // Launch a run and follow it cycle by cycle against the model.
  // poke >= 0 pulses start with other settings at that RUN cycle.
  task automatic do_run(input logic [15:0] sd, input int n, input int md, input int poke, input string tag);
    int cyc;
    int ed, ed2;
    mode = md;
    @(negedge clk);
    start = 1'b1; num_samples = n[15:0]; seed = sd;
    ref_err = 0; ref_max = 0; ref_sum = 0; ref_sat = 0;
    ref_err2 = 0; ref_max2 = 0; ref_sum2 = 0; ref_sat2 = 0;
    if (n != 0) begin
      exp_x = (sd == 16'h0000) ? 16'h0001 : sd;
      exp_y = ((sd ^ YMASK) == 16'h0000) ? 16'h0001 : (sd ^ YMASK);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < n + 3) begin
      check({tag, "_busy"}, busy1, 1'b1);
      check({tag, "_opx"}, x1, exp_x);
      check({tag, "_opy"}, y1, exp_y);
      ed  = int'({1'b0, exp_x}) + int'({1'b0, exp_y}) - int'(mock(md, exp_x, exp_y));
      if (ed < 0) ed = -ed;
      ed2 = int'({1'b0, exp_x}) + int'({1'b0, exp_y});
      if (ed != 0) ref_err++;
      if (ed > ref_max) ref_max = ed;
      ref_sum += ed;
      if (ref_sum > 64'd4294967295) begin ref_sum = 64'd4294967295; ref_sat = 1; end
      if (ed2 != 0) ref_err2++;
      if (ed2 > ref_max2) ref_max2 = ed2;
      ref_sum2 += ed2;
      if (ref_sum2 > 64'd65535) begin ref_sum2 = 64'd65535; ref_sat2 = 1; end
      exp_x = next_lfsr(exp_x);
      exp_y = next_lfsr(exp_y);
      if (cyc == poke) begin
        start = 1'b1; num_samples = 16'd3; seed = ~sd;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_busy_cycles"}, cyc, n);
    check({tag, "_done"}, done1, 1'b1);
    check({tag, "_busy_at_done"}, busy1, 1'b0);
    check({tag, "_done2"}, done2, 1'b1);
    check_stats(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done1, 1'b0);
    check({tag, "_idle_busy"}, busy1, 1'b0);
    check_stats({tag, "_hold"});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_samples = 16'd0; seed = 16'd0; mode = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_x", x1, 16'h0000);
    check("rst_y", y1, 16'h0000);
    check("rst_err", err1, 16'h0000);
    check("rst_max", max1, 17'h00000);
    check("rst_sum", sum1, 32'h0);
    check("rst_sat", sat1, 1'b0);
    rst = 1'b0;

    // Exact adder: no error at all.
    do_run(16'h1234, 1000, 0, -1, "exact");

    // Zero-output adder, single sample.
    do_run(16'h0001, 1, 1, -1, "zero1");
    check("zero1_max_const", max1, 17'h05A5C);
    check("zero1_sum_const", sum1, 32'h00005A5C);
    check("zero1_err_const", err1, 16'd1);

    // Zero sample count: immediate done, stats cleared, operands held.
    do_run(16'hBEEF, 0, 1, -1, "nzero");

    // Narrow accumulator saturation.
    do_run(16'hFFFF, 8, 1, -1, "sat");
    check("sat_sum2_const", sum2, 16'hFFFF);
    check("sat_flag_const", sat2, 1'b1);
    check("sat_err2_const", err2, 16'd8);

    // Seeds that would zero an LFSR.
    do_run(16'h0000, 5, 3, -1, "seedx0");
    do_run(YMASK, 5, 3, -1, "seedy0");

    // start during RUN is ignored.
    do_run(16'h7777, 50, 3, 10, "poke");

    // Randomized runs.
    for (int i = 0; i < 8; i++) begin
      do_run(16'($urandom), int'($urandom_range(0, 40)), int'($urandom_range(0, 3)), -1, "rand");
    end

    // Reset in the middle of a run.
    mode = 3;
    @(negedge clk);
    start = 1'b1; num_samples = 16'd100; seed = 16'h4321;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", busy1, 1'b0);
    check("mrst_done", done1, 1'b0);
    check("mrst_x", x1, 16'h0000);
    check("mrst_y", y1, 16'h0000);
    check("mrst_err", err1, 16'h0000);
    check("mrst_max", max1, 17'h00000);
    check("mrst_sum", sum1, 32'h0);
    check("mrst_sat", sat1, 1'b0);
    repeat (3) @(negedge clk);
    check("mrst_idle_busy", busy1, 1'b0);
    check("mrst_idle_done", done1, 1'b0);
    do_run(16'h4321, 100, 3, -1, "after_rst");

    // Approximate adder over a long run.
    do_run(16'hACE1, 65535, 2, -1, "hoeraa");
    check("hoeraa_err_nz", (err1 != 16'h0000), 1'b1);
    check("hoeraa_max_nz", (max1 != 17'h00000), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
